mem_access_unit: RTL and testbench

// - LC-3 memory interface stage: holds MAR and MDR and runs the read/write

---
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// LC-3 memory access stage: MAR/MDR registers and the REQ/ack handshake with external memory.
// Optional request timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_LD_MAR,
    input  logic              i_LD_MDR,
    input  logic              i_MIO_EN,
    input  logic              i_R_W,
    input  logic [DATA_W-1:0] i_Bus,
    output logic [ADDR_W-1:0] o_MAR,
    output logic [DATA_W-1:0] o_MDR,
    output logic              o_R,
    output logic              o_MEM_ERR,
    output logic              o_MEM_REQ,
    output logic              o_MEM_WE,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic [DATA_W-1:0] o_MEM_WDATA,
    input  logic [DATA_W-1:0] i_MEM_RDATA,
    input  logic              i_MEM_ACK
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic              we_q;
    logic              err_q, err_d;
    logic              timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Fires on the last REQ cycle of the allowed window.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N)            cnt_q <= '0;
        else if (state_q == IDLE) cnt_q <= '0;
        else if (state_q == REQ)  cnt_q <= cnt_q + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (i_MIO_EN) state_d = REQ;
            REQ: begin
                // Ack beats a coincident timeout.
                if (i_MEM_ACK) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            mar_q <= '0;
            mdr_q <= '0;
            we_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && i_MIO_EN)
                we_q <= i_R_W;
            if (state_q != REQ && i_LD_MAR)
                mar_q <= ADDR_W'(i_Bus);
            // Address and write data stay frozen while the request is outstanding.
            if (state_q == REQ) begin
                if (i_MEM_ACK && !we_q)
                    mdr_q <= i_MEM_RDATA;
            end else if (i_LD_MDR && !i_MIO_EN) begin
                mdr_q <= i_Bus;
            end
        end
    end

    assign o_MAR       = mar_q;
    assign o_MDR       = mdr_q;
    assign o_R         = (state_q == DONE);
    assign o_MEM_ERR   = err_q;
    assign o_MEM_REQ   = (state_q == REQ);
    assign o_MEM_WE    = (state_q == REQ) && we_q;
    assign o_MEM_ADDR  = mar_q;
    assign o_MEM_WDATA = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; timeout scenarios enabled when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          i_CLK = 1'b0;
    logic          i_RST_N = 1'b0;
    logic          i_LD_MAR = 1'b0, i_LD_MDR = 1'b0, i_MIO_EN = 1'b0, i_R_W = 1'b0;
    logic [DW-1:0] i_Bus = '0;
    logic [AW-1:0] o_MAR;
    logic [DW-1:0] o_MDR;
    logic          o_R, o_MEM_ERR, o_MEM_REQ, o_MEM_WE;
    logic [AW-1:0] o_MEM_ADDR;
    logic [DW-1:0] o_MEM_WDATA;
    logic [DW-1:0] i_MEM_RDATA = '0;
    logic          i_MEM_ACK = 1'b0;

    typedef struct {
        logic [DW-1:0] mdr;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_LD_MAR(i_LD_MAR), .i_LD_MDR(i_LD_MDR),
        .i_MIO_EN(i_MIO_EN), .i_R_W(i_R_W), .i_Bus(i_Bus), .o_MAR(o_MAR), .o_MDR(o_MDR),
        .o_R(o_R), .o_MEM_ERR(o_MEM_ERR), .o_MEM_REQ(o_MEM_REQ), .o_MEM_WE(o_MEM_WE),
        .o_MEM_ADDR(o_MEM_ADDR), .o_MEM_WDATA(o_MEM_WDATA), .i_MEM_RDATA(i_MEM_RDATA),
        .i_MEM_ACK(i_MEM_ACK)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // Pops the scoreboard on the o_R cycle and compares MDR/ERR.
    task automatic check_done(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: o_R seen with empty scoreboard", name);
            return;
        end
        e = exp_q.pop_front();
        if (o_R !== 1'b1 || o_MDR !== e.mdr || o_MEM_ERR !== e.err) begin
            errors++;
            $display("FAIL %s: R=%b MDR=%h ERR=%b, expected R=1 MDR=%h ERR=%b",
                     name, o_R, o_MDR, o_MEM_ERR, e.mdr, e.err);
        end
    endtask

    task automatic load_reg(input logic mar, input logic [DW-1:0] v);
        i_Bus = v; i_LD_MAR = mar; i_LD_MDR = !mar;
        tick();
        i_LD_MAR = 1'b0; i_LD_MDR = 1'b0;
    endtask

    task automatic test_reset();
        load_reg(1'b1, 16'h1111);
        load_reg(1'b0, 16'h2222);
        i_MIO_EN = 1'b1; i_R_W = 1'b0;
        tick();
        checks++;
        if (o_MEM_REQ !== 1'b1) begin
            errors++; $display("FAIL reset_pre_req: REQ=%b expected 1", o_MEM_REQ);
        end
        #2 i_RST_N = 1'b0;
        #1;
        checks++;
        if (o_MEM_REQ !== 1'b0 || o_MAR !== '0 || o_MDR !== '0 || o_R !== 1'b0 ||
            o_MEM_ERR !== 1'b0 || o_MEM_WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: REQ=%b MAR=%h MDR=%h R=%b ERR=%b WE=%b, expected all 0",
                     o_MEM_REQ, o_MAR, o_MDR, o_R, o_MEM_ERR, o_MEM_WE);
        end
        i_MIO_EN = 1'b0;
        tick();
        i_RST_N = 1'b1;
        tick();
        checks++;
        if (o_MEM_REQ !== 1'b0 || o_R !== 1'b0) begin
            errors++; $display("FAIL reset_idle: REQ=%b R=%b expected 0 0", o_MEM_REQ, o_R);
        end
    endtask

    task automatic test_fetch();
        load_reg(1'b1, 16'h3000);
        i_MIO_EN = 1'b1; i_R_W = 1'b0;
        exp_q.push_back('{mdr: 16'h1234, err: 1'b0});
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (o_MEM_REQ !== 1'b1 || o_MEM_ADDR !== 16'h3000 || o_MEM_WE !== 1'b0 || o_R !== 1'b0) begin
                errors++;
                $display("FAIL fetch_req%0d: REQ=%b ADDR=%h WE=%b R=%b, expected 1 3000 0 0",
                         c, o_MEM_REQ, o_MEM_ADDR, o_MEM_WE, o_R);
            end
            if (c == 3) begin
                i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h1234;
            end
        end
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("fetch_done");
        tick();
        checks++;
        if (o_R !== 1'b0 || o_MDR !== 16'h1234 || o_MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after: R=%b MDR=%h REQ=%b, expected 0 1234 0", o_R, o_MDR, o_MEM_REQ);
        end
    endtask

    task automatic test_write();
        load_reg(1'b1, 16'h4000);
        load_reg(1'b0, 16'hBEEF);
        i_MIO_EN = 1'b1; i_R_W = 1'b1;
        exp_q.push_back('{mdr: 16'hBEEF, err: 1'b0});
        tick();
        // Flip R_W mid-request; the latched direction must hold.
        i_R_W = 1'b0;
        checks++;
        if (o_MEM_WE !== 1'b1 || o_MEM_WDATA !== 16'hBEEF || o_MEM_ADDR !== 16'h4000) begin
            errors++;
            $display("FAIL write_req1: WE=%b WDATA=%h ADDR=%h, expected 1 BEEF 4000",
                     o_MEM_WE, o_MEM_WDATA, o_MEM_ADDR);
        end
        tick();
        checks++;
        if (o_MEM_WE !== 1'b1 || o_MEM_WDATA !== 16'hBEEF || o_MEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL write_req2: WE=%b WDATA=%h REQ=%b, expected 1 BEEF 1",
                     o_MEM_WE, o_MEM_WDATA, o_MEM_REQ);
        end
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h5555;
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("write_done");
        tick();
    endtask

    task automatic test_ignore_loads();
        i_MIO_EN = 1'b1; i_R_W = 1'b0;
        tick();
        i_Bus = 16'hFFFF; i_LD_MAR = 1'b1; i_LD_MDR = 1'b1;
        tick();
        i_LD_MAR = 1'b0; i_LD_MDR = 1'b0;
        checks++;
        if (o_MAR !== 16'h4000 || o_MDR !== 16'hBEEF) begin
            errors++;
            $display("FAIL ld_in_req: MAR=%h MDR=%h, expected 4000 BEEF", o_MAR, o_MDR);
        end
        exp_q.push_back('{mdr: 16'hA5A5, err: 1'b0});
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'hA5A5;
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("ld_ignore_done");
        // Spurious ack while idle.
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h0BAD;
        tick();
        tick();
        i_MEM_ACK = 1'b0;
        checks++;
        if (o_MDR !== 16'hA5A5 || o_R !== 1'b0 || o_MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack: MDR=%h R=%b REQ=%b, expected A5A5 0 0", o_MDR, o_R, o_MEM_REQ);
        end
    endtask

    task automatic test_back_to_back();
        // LD_MAR together with the start: transaction uses the new address.
        i_Bus = 16'h5000; i_LD_MAR = 1'b1; i_MIO_EN = 1'b1; i_R_W = 1'b0;
        tick();
        i_LD_MAR = 1'b0;
        checks++;
        if (o_MEM_REQ !== 1'b1 || o_MEM_ADDR !== 16'h5000) begin
            errors++;
            $display("FAIL ld_mar_start: REQ=%b ADDR=%h, expected 1 5000", o_MEM_REQ, o_MEM_ADDR);
        end
        exp_q.push_back('{mdr: 16'h7777, err: 1'b0});
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h7777;
        tick();
        i_MEM_ACK = 1'b0;
        check_done("b2b_first");
        tick();
        checks++;
        if (o_MEM_REQ !== 1'b0 || o_R !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: REQ=%b R=%b expected 0 0", o_MEM_REQ, o_R);
        end
        tick();
        checks++;
        if (o_MEM_REQ !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: REQ=%b expected 1", o_MEM_REQ);
        end
        exp_q.push_back('{mdr: 16'h8888, err: 1'b0});
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h8888;
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("b2b_second");
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles;
        bit seen;
        // No ack: without the timeout feature the request must persist.
        i_MIO_EN = 1'b1; i_R_W = 1'b0;
        req_cycles = 0; seen = 0;
`ifdef MEM_TIMEOUT_EN
        exp_q.push_back('{mdr: 16'h8888, err: 1'b1});
`endif
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (o_MEM_REQ === 1'b1) req_cycles++;
            if (o_R === 1'b1) seen = 1;
        end
`ifdef MEM_TIMEOUT_EN
        checks++;
        if (!seen || req_cycles != TO) begin
            errors++;
            $display("FAIL timeout_abort: seen=%0d req_cycles=%0d, expected 1 %0d", seen, req_cycles, TO);
        end
        if (seen) check_done("timeout_done");
        i_MIO_EN = 1'b0;
        tick();
        // Ack on the last allowed cycle wins over the timeout.
        i_MIO_EN = 1'b1;
        exp_q.push_back('{mdr: 16'h9999, err: 1'b0});
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == TO) begin
                i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h9999;
            end
        end
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("timeout_ack_wins");
        tick();
`else
        checks++;
        if (seen || o_MEM_REQ !== 1'b1 || o_MEM_ERR !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: R_seen=%0d REQ=%b ERR=%b, expected 0 1 0", seen, o_MEM_REQ, o_MEM_ERR);
        end
        exp_q.push_back('{mdr: 16'h9999, err: 1'b0});
        i_MEM_ACK = 1'b1; i_MEM_RDATA = 16'h9999;
        tick();
        i_MEM_ACK = 1'b0; i_MIO_EN = 1'b0;
        check_done("late_ack");
        tick();
`endif
    endtask

    initial begin
        tick();
        i_RST_N = 1'b1;
        tick();
        test_reset();
        test_fetch();
        test_write();
        test_ignore_loads();
        test_back_to_back();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
